// File: rtl/placement_cost_eval_if.sv
// Memory-side bus of placement_cost_eval: edge-list read port and shared X/Y position read port.
// master = evaluator (drives strobes/addresses), slave = memories (return data one cycle after a visible strobe).
interface placement_cost_eval_if #(
    parameter int DATA_W  = 32,
    parameter int EDGE_AW = 10,
    parameter int POS_AW  = 7
);
    logic               edge_re;
    logic [EDGE_AW-1:0] edge_addr;
    logic [DATA_W-1:0]  edge_a;
    logic [DATA_W-1:0]  edge_b;
    logic               pos_re;
    logic [POS_AW-1:0]  pos_addr;
    logic [DATA_W-1:0]  pos_x;
    logic [DATA_W-1:0]  pos_y;

    modport master (
        output edge_re, edge_addr,
        input  edge_a, edge_b,
        output pos_re, pos_addr,
        input  pos_x, pos_y
    );

    modport slave (
        input  edge_re, edge_addr,
        output edge_a, edge_b,
        input  pos_re, pos_addr,
        output pos_x, pos_y
    );
endinterface

// File: rtl/placement_cost_eval.sv
// Wirelength evaluator: walks the edge list, accumulates Manhattan and hop cost, counts unplaced edges.
// Optional macro PLACE_EVAL_MAXLEN_EN adds the max_len output (largest |dx|+|dy| over placed edges).
module placement_cost_eval #(
    parameter int DATA_W    = 32,
    parameter int EDGE_AW   = 10,
    parameter int POS_AW    = 7,
    parameter int SUM_W     = 32,
    parameter int HOP_SHIFT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [EDGE_AW:0]        n_edge,
    output logic                    busy,
    output logic                    done,
    placement_cost_eval_if.master   mem,
    output logic signed [SUM_W-1:0] sum,
    output logic signed [SUM_W-1:0] sum_hop,
    output logic [EDGE_AW:0]        n_unplaced,
`ifdef PLACE_EVAL_MAXLEN_EN
    output logic [DATA_W-1:0]       max_len,
`endif
    output logic                    err_unplaced
);

    typedef enum logic [3:0] {
        IDLE, RD_E, WT_E, RD_A, WT_A, RD_B, WT_B, ACC, DONE
    } state_t;

    localparam logic [DATA_W-1:0]  UNPLACED = {DATA_W{1'b1}};
    localparam logic [DATA_W+1:0]  HOP_ADD  = ~({(DATA_W+2){1'b1}} << HOP_SHIFT);
    localparam logic [EDGE_AW:0]   CNT_ZERO = {(EDGE_AW+1){1'b0}};
    localparam logic [EDGE_AW:0]   CNT_ONE  = {{EDGE_AW{1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0]   SUM_ONE  = {{(SUM_W-1){1'b0}}, 1'b1};

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [EDGE_AW:0]          n_edge_r;
    logic [EDGE_AW:0]          idx_r;
    logic [POS_AW-1:0]         eb_r;
    logic signed [DATA_W-1:0]  xa_r, ya_r, xb_r, yb_r;
    logic                      acc_phase_r;

    logic [DATA_W:0]           dx_s, dy_s;
    logic [DATA_W+1:0]         len_s;
    logic [DATA_W+1:0]         hop_s;
    logic [SUM_W-1:0]          cost_s;
    logic [SUM_W-1:0]          cost_hop_s;
    logic                      unplaced_s;
    logic                      last_edge_s;
    logic                      unused_bits_s;

    function automatic logic [DATA_W:0] abs_diff(input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        return d[DATA_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

    // ceil(d / 2^HOP_SHIFT), computed one bit wider so the rounding add cannot overflow
    function automatic logic [DATA_W+1:0] hop_term(input logic [DATA_W:0] d);
        return ({1'b0, d} + HOP_ADD) >> HOP_SHIFT;
    endfunction

    // Per-edge cost from the captured endpoint coordinates
    always_comb begin
        dx_s        = abs_diff(xa_r, xb_r);
        dy_s        = abs_diff(ya_r, yb_r);
        len_s       = {1'b0, dx_s} + {1'b0, dy_s};
        hop_s       = hop_term(dx_s) + hop_term(dy_s);
        cost_s      = SUM_W'(len_s) - SUM_ONE;
        cost_hop_s  = SUM_W'(hop_s) - SUM_ONE;
        unplaced_s  = (xa_r == UNPLACED) || (ya_r == UNPLACED) ||
                      (xb_r == UNPLACED) || (yb_r == UNPLACED);
        last_edge_s = ((idx_r + CNT_ONE) == n_edge_r);
    end

    assign unused_bits_s = ^{mem.edge_a[DATA_W-1:POS_AW], mem.edge_b[DATA_W-1:POS_AW]};

    // Next-state logic; ACC spends one cycle capturing B and one accumulating
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (n_edge == CNT_ZERO) ? DONE : RD_E;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_E: state_nxt_s = WT_E;
            WT_E: state_nxt_s = RD_A;
            RD_A: state_nxt_s = WT_A;
            WT_A: state_nxt_s = RD_B;
            RD_B: state_nxt_s = WT_B;
            WT_B: state_nxt_s = ACC;
            ACC: begin
                if (!acc_phase_r) begin
                    state_nxt_s = ACC;
                end else if (last_edge_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RD_E;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs, memory strobes and datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            mem.edge_re   <= 1'b0;
            mem.edge_addr <= {EDGE_AW{1'b0}};
            mem.pos_re    <= 1'b0;
            mem.pos_addr  <= {POS_AW{1'b0}};
            sum           <= {SUM_W{1'b0}};
            sum_hop       <= {SUM_W{1'b0}};
            n_unplaced    <= CNT_ZERO;
            err_unplaced  <= 1'b0;
`ifdef PLACE_EVAL_MAXLEN_EN
            max_len       <= {DATA_W{1'b0}};
`endif
            n_edge_r      <= CNT_ZERO;
            idx_r         <= CNT_ZERO;
            eb_r          <= {POS_AW{1'b0}};
            xa_r          <= {DATA_W{1'b0}};
            ya_r          <= {DATA_W{1'b0}};
            xb_r          <= {DATA_W{1'b0}};
            yb_r          <= {DATA_W{1'b0}};
            acc_phase_r   <= 1'b0;
        end else begin
            busy        <= (state_nxt_s != IDLE) && (state_nxt_s != DONE);
            done        <= (state_nxt_s == DONE);
            mem.edge_re <= (state_r == RD_E);
            mem.pos_re  <= (state_r == RD_A) || (state_r == RD_B);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        n_edge_r     <= n_edge;
                        idx_r        <= CNT_ZERO;
                        sum          <= {SUM_W{1'b0}};
                        sum_hop      <= {SUM_W{1'b0}};
                        n_unplaced   <= CNT_ZERO;
                        err_unplaced <= 1'b0;
`ifdef PLACE_EVAL_MAXLEN_EN
                        max_len      <= {DATA_W{1'b0}};
`endif
                    end
                end
                RD_E: mem.edge_addr <= idx_r[EDGE_AW-1:0];
                RD_A: begin
                    mem.pos_addr <= mem.edge_a[POS_AW-1:0];
                    eb_r         <= mem.edge_b[POS_AW-1:0];
                end
                RD_B: begin
                    xa_r         <= mem.pos_x;
                    ya_r         <= mem.pos_y;
                    mem.pos_addr <= eb_r;
                end
                ACC: begin
                    if (!acc_phase_r) begin
                        xb_r        <= mem.pos_x;
                        yb_r        <= mem.pos_y;
                        acc_phase_r <= 1'b1;
                    end else begin
                        acc_phase_r <= 1'b0;
                        idx_r       <= idx_r + CNT_ONE;
                        if (unplaced_s) begin
                            n_unplaced   <= n_unplaced + CNT_ONE;
                            err_unplaced <= 1'b1;
                        end else begin
                            sum     <= sum + cost_s;
                            sum_hop <= sum_hop + cost_hop_s;
`ifdef PLACE_EVAL_MAXLEN_EN
                            if (len_s > {2'b00, max_len}) begin
                                max_len <= len_s[DATA_W-1:0];
                            end
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
